cntr_rr_sched: RTL

Round-robin scheduler that shares one reloadable 8-bit up-counter among N_REQ requesters. Each requester supplies its own start value. The block grants the counter to one requester at a time, loads that requester's value, counts up to terminal count, and then pulses a per-requester done before re-arbitrating. It sits above the counter/reload-register datapath as its sequencer, and contains its own counter so that it is self-contained.

---
 rtl/cntr_rr_sched.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/cntr_rr_sched.sv
// Round-robin sequencer sharing one reloadable up-counter among requesters.
// Grants one requester, counts its start value up to all-ones, pulses done.
module cntr_rr_sched #(
    parameter int N_REQ = 4,
    parameter int W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] load_val,
    input  logic               abort,
    output logic               busy,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic [W-1:0]       count,
    output logic               tc
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic             busy_q, busy_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [W-1:0]     count_q, count_d;
    logic [IW-1:0]    last_q, last_d;

    logic             win_vld;
    logic [IW-1:0]    win_idx;
    logic [N_REQ-1:0] win_oh;
    logic [IW:0]      cand;
    logic [W-1:0]     load_sel;
    logic             at_max;
    logic             start;

    assign at_max = (count_q == CNT_MAX);
    assign start  = !abort && win_vld;

    // Search upward from the slot after the last winner, wrapping around.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, last_q} + (IW+1)'(i + 1);
            if (cand >= (IW+1)'(N_REQ)) begin
                cand = cand - (IW+1)'(N_REQ);
            end
            if (!win_vld && req[cand[IW-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        win_oh   = '0;
        load_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == IW'(i)) begin
                win_oh[i] = 1'b1;
                load_sel  = load_val[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (at_max) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy_d  = busy_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        count_d = count_q;
        last_d  = last_q;
        unique case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                gnt_d  = '0;
                if (start) begin
                    busy_d  = 1'b1;
                    gnt_d   = win_oh;
                    count_d = load_sel;
                    last_d  = win_idx;
                end
            end
            S_RUN: begin
                if (abort) begin
                    busy_d  = 1'b0;
                    gnt_d   = '0;
                    count_d = '0;
                end else if (at_max) begin
                    done_d = gnt_q;
                end else begin
                    count_d = count_q + W'(1);
                end
            end
            S_DONE: begin
                busy_d = 1'b0;
                gnt_d  = '0;
                if (abort) begin
                    count_d = '0;
                end
            end
            default: begin
                busy_d  = 1'b0;
                gnt_d   = '0;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q  <= 1'b0;
            gnt_q   <= '0;
            done_q  <= '0;
            count_q <= '0;
            last_q  <= IW'(N_REQ - 1);
        end else begin
            busy_q  <= busy_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

    assign busy  = busy_q;
    assign gnt   = gnt_q;
    assign done  = done_q;
    assign count = count_q;
    assign tc    = (state_q == S_RUN) && at_max;

endmodule
